pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Sequencing controller for the 5-stage pipeline's four stage registers (1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB) and the PC.

- Each cycle it decides per-stage enable/flush from four conditions: instruction/data memory wait, load-use hazard, taken branch/jump redirect, and halt.
- A small FSM tracks init, memory wait and halted state.
- Saturating counters report stall and flush cycles.
- It sits beside the stage registers, which hold when `en_n`=0 and load zeros when `en_n`=1 and `flush_n`=1.

## Interface
Parameters:
- `CNT_W`, 16, width of the performance counters.

Ports:
- `CLK`  in  1  clock, all state updates on rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ihit`  in  1  instruction fetch complete this cycle.
- `dhit`  in  1  data access complete this cycle.
- `dREN_3`, `dWEN_3`  in  1 each  load/store sitting at register 3 output.
- `ld_2`  in  1  register 2 output holds a load (`dREN_out_2`).
- `wsel_2`  in  5  destination register of the register-2 instruction.
- `rs_1`, `rt_1`  in  5 each  source fields of the register-1 instruction.
- `uses_rt_1`  in  1  register-1 instruction reads rt.
- `branch_taken_3`  in  1  beq/bne at register 3 output resolved taken.
- `jump_2`  in  1  j/jal/JR at register 2 output.
- `halt_4`  in  1  halt at register 4 output.
- `pc_en`  out  1  PC load enable.
- `pc_sel`  out  2  0 = pc+4, 1 = branch target, 2 = jump target; 3 is never driven.
- `en_1`..`en_4`  out  1 each  stage register enables.
- `flush_1`..`flush_3`  out  1 each  stage register clears (effective only with `en`=1).
- `halted`  out  1  core halted.
- `stall_cnt`  out  `CNT_W`  cycles with `pc_en`=0 in RUN/MEMWAIT.
- `flush_cnt`  out  `CNT_W`  cycles with a branch or jump redirect.

## Operation
- FSM states are INIT, RUN, MEMWAIT and HALTED. All outputs are combinational from state and inputs.
- INIT (held while `nRST`=0, lasts one cycle after release):
  - Outputs are independent of inputs: `pc_en`=0, `en_1..4`=1, `flush_1..3`=1, `pc_sel`=0, `halted`=0.
  - Next state is RUN.
- Counters reset to 0 asynchronously.
- RUN and MEMWAIT use the same priority evaluation, highest first:
  1. `halt_4`: all `en`=0, `pc_en`=0, next state HALTED.
  2. Memory wait, `(dREN_3|dWEN_3)&!dhit`: all `en`=0, `pc_en`=0, no flush, next state MEMWAIT. In MEMWAIT, branch, jump and hazard inputs are ignored until `dhit`.
  3. `branch_taken_3`: all `en`=1, `flush_1..3`=1, `pc_en`=1, `pc_sel`=1.
  4. `jump_2`: all `en`=1, `flush_1`=1, `flush_2`=1, `pc_en`=1, `pc_sel`=2.
  5. Load-use: `ld_2 & wsel_2!=0 & (wsel_2==rs_1 | (uses_rt_1 & wsel_2==rt_1))`.
     - Response: `pc_en`=0, `en_1`=0, `en_2..4`=1, `flush_2`=1.
     - Register 1 holds its instruction.
  6. `!ihit`: `pc_en`=0, all `en`=1, `flush_1`=1 (bubble).
  7. Otherwise: `pc_en`=1, all `en`=1, no flush, `pc_sel`=0.
- When none of items 1–2 applies, the next state is RUN.
- MEMWAIT exits on the cycle `dhit`=1. That cycle is evaluated from item 3 down, and the next state is RUN.
- Items 3/4 override `!ihit`: the PC still redirects, and `flush_1` discards the partial fetch.
- Load-use with `!ihit` uses the load-use response only.
- HALTED:
  - `halted`=1, all `en`=0, `pc_en`=0, all flush=0.
  - Counters freeze.
  - Only `nRST` exits.
- Counters:
  - `stall_cnt` +1 on each RUN/MEMWAIT cycle with `pc_en`=0.
  - `flush_cnt` +1 on each cycle where item 3 or 4 fires.
  - Both saturate at all-ones; they never wrap.

## Timing
- Decisions are same-cycle (combinational). State and counters update at the rising `CLK` edge.
- `nRST` falling edge forces INIT mid-operation; counters clear immediately.
- Penalties:
  - Taken branch: 3 bubbles.
  - Jump: 2 bubbles.
  - Load-use: 1 bubble.
  - `!ihit`: 1 bubble per miss cycle.
  - Data wait: N frozen cycles for N cycles of `!dhit`.
- A simultaneous `halt_4` and memory wait enters HALTED. The pending access is abandoned.

## Test plan
- **Reset.** Assert `nRST`=0 mid-run, then release.
  - Required: the INIT cycle shows `pc_en`=0 and `flush_1..3`=1; RUN follows; both counters are 0.
- **Load-use.** `ld_2`=1, `wsel_2`=5, `rs_1`=5, `ihit`=1.
  - Required: `pc_en`=0, `en_1`=0, `flush_2`=1; `stall_cnt` 0→1.
  - With `wsel_2`=0 instead: no stall.
- **Data wait.** `dREN_3`=1, `dhit`=0 for 3 cycles, then 1.
  - Required: all `en`=0 for 3 cycles and `stall_cnt`=3.
  - Required: `branch_taken_3`=1 asserted during the wait has no effect until the `dhit` cycle, where `pc_sel`=1 and `flush_1..3`=1.
- **Branch beats jump and miss.** `branch_taken_3`=1, `jump_2`=1, `ihit`=0.
  - Required: `pc_sel`=1, `pc_en`=1, `flush_1..3`=1; `flush_cnt`+1.
- **Halt.** `halt_4`=1 together with `dREN_3`=1, `dhit`=0.
  - Required: `halted`=1 next cycle; all enables stay 0 for 10 further cycles; counters unchanged.
- **Saturation.** Force `CNT_W`=4 and hold `ihit`=0 for 20 cycles.
  - Required: `stall_cnt` stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enable/flush, PC select and
// stall/flush performance counters for the 5-stage core.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_3,
    input  logic             dWEN_3,
    input  logic             ld_2,
    input  logic [4:0]       wsel_2,
    input  logic [4:0]       rs_1,
    input  logic [4:0]       rt_1,
    input  logic             uses_rt_1,
    input  logic             branch_taken_3,
    input  logic             jump_2,
    input  logic             halt_4,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             en_1,
    output logic             en_2,
    output logic             en_3,
    output logic             en_4,
    output logic             flush_1,
    output logic             flush_2,
    output logic             flush_3,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] INIT    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] MEMWAIT = 2'd2;
    localparam logic [1:0] HALTED  = 2'd3;

    localparam logic [1:0] SEL_PC4 = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_JMP = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       load_use;
    logic       mem_wait;
    logic       active;
    logic       redirect;

    // Hazard detection; once frozen, only dhit releases the pipeline
    always_comb begin
        load_use = ld_2 && (wsel_2 != 5'd0) &&
                   ((wsel_2 == rs_1) || (uses_rt_1 && (wsel_2 == rt_1)));
        mem_wait = (state == MEMWAIT) ? !dhit : ((dREN_3 || dWEN_3) && !dhit);
        active   = (state == RUN) || (state == MEMWAIT);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-stage control, priority highest first
    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        pc_sel     = SEL_PC4;
        en_1       = 1'b0;
        en_2       = 1'b0;
        en_3       = 1'b0;
        en_4       = 1'b0;
        flush_1    = 1'b0;
        flush_2    = 1'b0;
        flush_3    = 1'b0;
        halted     = 1'b0;
        redirect   = 1'b0;
        case (state)
            INIT: begin
                {en_1, en_2, en_3, en_4}  = 4'b1111;
                {flush_1, flush_2, flush_3} = 3'b111;
                next_state = RUN;
            end
            RUN, MEMWAIT: begin
                next_state = RUN;
                {en_1, en_2, en_3, en_4} = 4'b1111;
                if (halt_4) begin
                    {en_1, en_2, en_3, en_4} = 4'b0000;
                    next_state = HALTED;
                end else if (mem_wait) begin
                    {en_1, en_2, en_3, en_4} = 4'b0000;
                    next_state = MEMWAIT;
                end else if (branch_taken_3) begin
                    {flush_1, flush_2, flush_3} = 3'b111;
                    pc_en    = 1'b1;
                    pc_sel   = SEL_BR;
                    redirect = 1'b1;
                end else if (jump_2) begin
                    flush_1  = 1'b1;
                    flush_2  = 1'b1;
                    pc_en    = 1'b1;
                    pc_sel   = SEL_JMP;
                    redirect = 1'b1;
                end else if (load_use) begin
                    // Hold IF/ID, inject a bubble into ID/EX
                    en_1    = 1'b0;
                    flush_2 = 1'b1;
                end else if (!ihit) begin
                    flush_1 = 1'b1;
                end else begin
                    pc_en = 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    // Saturating performance counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (active && !pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for RUN-state
// decisions plus hand sequences for reset, data wait, halt and saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    // {pc_en, pc_sel[1:0], en_1..en_4, flush_1..flush_3, halted}
    localparam logic [10:0] NORM = 11'b1_00_1111_000_0;
    localparam logic [10:0] LDU  = 11'b0_00_0111_010_0;
    localparam logic [10:0] BUB  = 11'b0_00_1111_100_0;
    localparam logic [10:0] BRN  = 11'b1_01_1111_111_0;
    localparam logic [10:0] JMP  = 11'b1_10_1111_110_0;
    localparam logic [10:0] INI  = 11'b0_00_1111_111_0;
    localparam logic [10:0] FRZ  = 11'b0_00_0000_000_0;
    localparam logic [10:0] HLT  = 11'b0_00_0000_000_1;

    logic CLK, nRST;
    logic ihit, dhit, dREN_3, dWEN_3, ld_2, uses_rt_1;
    logic branch_taken_3, jump_2, halt_4;
    logic [4:0] wsel_2, rs_1, rt_1;

    logic pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halted;
    logic [1:0] pc_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_en_1, s_en_2, s_en_3, s_en_4, s_flush_1, s_flush_2, s_flush_3, s_halted;
    logic [1:0] s_pc_sel;
    logic [3:0] s_stall, s_flush;

    logic [10:0] outs, s_outs;
    assign outs   = {pc_en, pc_sel, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halted};
    assign s_outs = {s_pc_en, s_pc_sel, s_en_1, s_en_2, s_en_3, s_en_4,
                     s_flush_1, s_flush_2, s_flush_3, s_halted};

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_3(dREN_3), .dWEN_3(dWEN_3),
        .ld_2(ld_2), .wsel_2(wsel_2), .rs_1(rs_1), .rt_1(rt_1), .uses_rt_1(uses_rt_1),
        .branch_taken_3(branch_taken_3), .jump_2(jump_2), .halt_4(halt_4),
        .pc_en(pc_en), .pc_sel(pc_sel), .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4),
        .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_3(dREN_3), .dWEN_3(dWEN_3),
        .ld_2(ld_2), .wsel_2(wsel_2), .rs_1(rs_1), .rt_1(rt_1), .uses_rt_1(uses_rt_1),
        .branch_taken_3(branch_taken_3), .jump_2(jump_2), .halt_4(halt_4),
        .pc_en(s_pc_en), .pc_sel(s_pc_sel), .en_1(s_en_1), .en_2(s_en_2), .en_3(s_en_3),
        .en_4(s_en_4), .flush_1(s_flush_1), .flush_2(s_flush_2), .flush_3(s_flush_3),
        .halted(s_halted), .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit;
        logic        ld;
        logic [4:0]  wsel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic        br;
        logic        jmp;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b1; dREN_3 = 1'b0; dWEN_3 = 1'b0;
        ld_2 = 1'b0; wsel_2 = 5'd0; rs_1 = 5'd0; rt_1 = 5'd0; uses_rt_1 = 1'b0;
        branch_taken_3 = 1'b0; jump_2 = 1'b0; halt_4 = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[1]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, LDU};
        vecs[2]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[3]  = '{1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, LDU};
        vecs[4]  = '{1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, NORM};
        vecs[5]  = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[6]  = '{1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, LDU};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, BUB};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, BRN};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, JMP};
        vecs[10] = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, JMP};
        vecs[11] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, BRN};
        vecs[12] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM};

        // Power-on reset and the single INIT cycle
        set_idle();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset outs", 32'(outs), 32'(INI));
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset flush_cnt", 32'(flush_cnt), 32'd0);
        nRST = 1'b1;
        #3;
        check("init cycle outs", 32'(outs), 32'(INI));
        @(posedge CLK); #1;
        check("run after init", 32'(outs), 32'(NORM));

        // RUN-state decision table
        for (int i = 0; i < 13; i++) begin
            ihit = vecs[i].ihit; ld_2 = vecs[i].ld; wsel_2 = vecs[i].wsel;
            rs_1 = vecs[i].rs; rt_1 = vecs[i].rt; uses_rt_1 = vecs[i].uses_rt;
            branch_taken_3 = vecs[i].br; jump_2 = vecs[i].jmp;
            #3;
            check($sformatf("vec%0d outs", i), 32'(outs), 32'(vecs[i].exp));
            if (!vecs[i].exp[10]) m_stall++;
            if (vecs[i].exp[9:8] != 2'd0) m_flush++;
            @(posedge CLK); #1;
            check($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(m_stall));
            check($sformatf("vec%0d flush_cnt", i), 32'(flush_cnt), 32'(m_flush));
        end

        // Mid-run reset clears counters without waiting for a clock
        set_idle();
        nRST = 1'b0;
        #1;
        check("midrst stall_cnt", 32'(stall_cnt), 32'd0);
        check("midrst flush_cnt", 32'(flush_cnt), 32'd0);
        check("midrst outs", 32'(outs), 32'(INI));
        @(posedge CLK); #1;
        nRST = 1'b1;
        #3;
        check("midrst init cycle", 32'(outs), 32'(INI));
        @(posedge CLK); #1;
        check("midrst run", 32'(outs), 32'(NORM));

        // Data wait of 3 cycles with a taken branch held throughout
        dREN_3 = 1'b1; dhit = 1'b0; branch_taken_3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("dwait%0d outs", i), 32'(outs), 32'(FRZ));
            @(posedge CLK); #1;
        end
        dhit = 1'b1;
        #3;
        check("dhit branch outs", 32'(outs), 32'(BRN));
        @(posedge CLK); #1;
        dREN_3 = 1'b0; branch_taken_3 = 1'b0;
        check("dwait stall_cnt", 32'(stall_cnt), 32'd3);
        check("dwait flush_cnt", 32'(flush_cnt), 32'd1);
        #3;
        check("after dwait outs", 32'(outs), 32'(NORM));
        @(posedge CLK); #1;

        // Halt together with a pending load wait
        halt_4 = 1'b1; dREN_3 = 1'b1; dhit = 1'b0;
        #3;
        check("halt cycle outs", 32'(outs), 32'(FRZ));
        @(posedge CLK); #1;
        halt_4 = 1'b0; dREN_3 = 1'b0; dhit = 1'b1; ihit = 1'b0; branch_taken_3 = 1'b1;
        check("halt stall_cnt", 32'(stall_cnt), 32'd4);
        check("halt flush_cnt", 32'(flush_cnt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            #3;
            check($sformatf("halted%0d outs", i), 32'(outs), 32'(HLT));
            @(posedge CLK); #1;
        end
        check("halted stall_cnt", 32'(stall_cnt), 32'd4);
        check("halted flush_cnt", 32'(flush_cnt), 32'd1);

        // Saturation of a 4-bit stall counter under a long fetch miss
        set_idle();
        nRST = 1'b0;
        #1;
        check("sat reset", 32'(s_stall), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            #3;
            check($sformatf("sat%0d outs", i), 32'(s_outs), 32'(BUB));
            @(posedge CLK); #1;
            check($sformatf("sat%0d stall_cnt", i), 32'(s_stall), 32'((i > 15) ? 15 : i));
        end
        check("sat flush_cnt", 32'(s_flush), 32'd0);
        check("wide stall_cnt", 32'(stall_cnt), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
